// File: rtl/grain_inject_if.sv
// Pixel stream bundle for grain_inject: input (s_*) and output (m_*) handshakes.
interface grain_inject_if #(
  parameter int CHANNEL_W = 8
);
  logic                     s_valid_in;
  logic                     s_ready_out;
  logic [3*CHANNEL_W-1:0]   s_data_in;
  logic                     s_last_in;
  logic                     m_valid_out;
  logic                     m_ready_in;
  logic [3*CHANNEL_W-1:0]   m_data_out;
  logic                     m_last_out;

  modport slave (
    input  s_valid_in, s_data_in, s_last_in, m_ready_in,
    output s_ready_out, m_valid_out, m_data_out, m_last_out
  );

  modport master (
    output s_valid_in, s_data_in, s_last_in, m_ready_in,
    input  s_ready_out, m_valid_out, m_data_out, m_last_out
  );
endinterface

// File: rtl/grain_inject.sv
// Film-grain injector: adds scaled pseudo-random noise to each RGB channel,
// clamps to the channel range and counts pixels that clipped.
// Two-stage pipeline: S1 captures pixel + scaled noise, S2 holds the result.
module grain_inject #(
  parameter int CHANNEL_W = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] rand_in,
  input  logic        enable_in,
  input  logic        chroma_in,
  input  logic [3:0]  strength_in,
  input  logic        clear_in,
  output logic [15:0] sat_count_out,
  grain_inject_if.slave bus
);

  localparam int PIX_W = 3*CHANNEL_W;
  localparam int SUM_W = (CHANNEL_W + 2 > 13) ? CHANNEL_W + 2 : 13;
  localparam logic signed [SUM_W-1:0] CH_MAX = SUM_W'((1 << CHANNEL_W) - 1);

  // noise byte (signed) times strength, arithmetic shift floors toward -inf
  function automatic logic signed [11:0] scale_noise(input logic [7:0] b, input logic [3:0] s);
    logic signed [12:0] prod;
    logic signed [12:0] shr;
    prod = $signed(b) * $signed({1'b0, s});
    shr  = prod >>> 3;
    return shr[11:0];
  endfunction

  // returns {clipped, clamped channel}; sum is wide enough to never overflow
  function automatic logic [CHANNEL_W:0] add_clamp(input logic [CHANNEL_W-1:0] ch,
                                                   input logic signed [11:0] n);
    logic signed [SUM_W-1:0] sum;
    sum = $signed({{(SUM_W-CHANNEL_W){1'b0}}, ch}) + $signed({{(SUM_W-12){n[11]}}, n});
    if (sum[SUM_W-1])       return {1'b1, {CHANNEL_W{1'b0}}};
    else if (sum > CH_MAX)  return {1'b1, {CHANNEL_W{1'b1}}};
    else                    return {1'b0, sum[CHANNEL_W-1:0]};
  endfunction

  logic                    r_v1, r_v2;
  logic [PIX_W-1:0]        r_data1, r_data2;
  logic                    r_last1, r_last2;
  logic                    r_clip2;
  logic signed [11:0]      r_noise_r1, r_noise_g1, r_noise_b1;
  logic                    r_enable, r_chroma;
  logic [3:0]              r_strength;
  logic                    r_line_start;
  logic [15:0]             r_sat;

  logic                    w_s2_can, w_s1_can, w_accept, w_consume;
  logic                    w_en_eff, w_chroma_eff;
  logic [3:0]              w_str_eff;
  logic [7:0]              w_byte_r, w_byte_g, w_byte_b;
  logic [CHANNEL_W:0]      w_res_r, w_res_g, w_res_b;
  logic                    w_clip_take;

  assign w_consume  = r_v2 & bus.m_ready_in;
  assign w_s2_can   = ~r_v2 | bus.m_ready_in;
  assign w_s1_can   = ~r_v1 | w_s2_can;
  assign w_accept   = bus.s_valid_in & w_s1_can;

  // first beat of a line uses the live inputs, the rest of the line the latched copy
  assign w_en_eff     = r_line_start ? enable_in   : r_enable;
  assign w_chroma_eff = r_line_start ? chroma_in   : r_chroma;
  assign w_str_eff    = w_en_eff ? (r_line_start ? strength_in : r_strength) : 4'd0;

  assign w_byte_r = rand_in[7:0];
  assign w_byte_g = w_chroma_eff ? rand_in[15:8] : rand_in[7:0];
  assign w_byte_b = w_chroma_eff ? rand_in[11:4] : rand_in[7:0];

  assign w_res_r = add_clamp(r_data1[PIX_W-1 -: CHANNEL_W],     r_noise_r1);
  assign w_res_g = add_clamp(r_data1[2*CHANNEL_W-1 -: CHANNEL_W], r_noise_g1);
  assign w_res_b = add_clamp(r_data1[CHANNEL_W-1:0],             r_noise_b1);

  assign w_clip_take = w_consume & r_clip2;

  assign bus.s_ready_out = w_s1_can;
  assign bus.m_valid_out = r_v2;
  assign bus.m_data_out  = r_data2;
  assign bus.m_last_out  = r_last2;
  assign sat_count_out   = r_sat;

  // latch line settings on the first accepted beat of each line
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_enable     <= 1'b0;
      r_chroma     <= 1'b0;
      r_strength   <= 4'd0;
      r_line_start <= 1'b1;
    end else if (w_accept) begin
      if (r_line_start) begin
        r_enable   <= enable_in;
        r_chroma   <= chroma_in;
        r_strength <= strength_in;
      end
      r_line_start <= bus.s_last_in;
    end
  end

  // S1: capture pixel, last flag and scaled noise for each channel
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_v1       <= 1'b0;
      r_data1    <= '0;
      r_last1    <= 1'b0;
      r_noise_r1 <= '0;
      r_noise_g1 <= '0;
      r_noise_b1 <= '0;
    end else if (w_s1_can) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_data1    <= bus.s_data_in;
        r_last1    <= bus.s_last_in;
        r_noise_r1 <= scale_noise(w_byte_r, w_str_eff);
        r_noise_g1 <= scale_noise(w_byte_g, w_str_eff);
        r_noise_b1 <= scale_noise(w_byte_b, w_str_eff);
      end
    end
  end

  // S2: clamped result, held while the consumer stalls
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_v2    <= 1'b0;
      r_data2 <= '0;
      r_last2 <= 1'b0;
      r_clip2 <= 1'b0;
    end else if (w_s2_can) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data2 <= {w_res_r[CHANNEL_W-1:0], w_res_g[CHANNEL_W-1:0], w_res_b[CHANNEL_W-1:0]};
        r_last2 <= r_last1;
        r_clip2 <= w_res_r[CHANNEL_W] | w_res_g[CHANNEL_W] | w_res_b[CHANNEL_W];
      end
    end
  end

  // saturating count of consumed clipped beats; clear still counts a same-cycle clip
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_sat <= 16'd0;
    else if (clear_in)
      r_sat <= w_clip_take ? 16'd1 : 16'd0;
    else if (w_clip_take && (r_sat != 16'hFFFF))
      r_sat <= r_sat + 16'd1;
  end

endmodule

// File: tb/tb_grain_inject.sv
// Directed testbench for grain_inject with hand-computed expected pixels.
module tb_grain_inject;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] rand_in;
  logic        enable_in, chroma_in, clear_in;
  logic [3:0]  strength_in;
  logic [15:0] sat_count_out;

  int tests = 0;
  int fails = 0;

  grain_inject_if #(.CHANNEL_W(8)) bus();

  grain_inject #(.CHANNEL_W(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rand_in       (rand_in),
    .enable_in     (enable_in),
    .chroma_in     (chroma_in),
    .strength_in   (strength_in),
    .clear_in      (clear_in),
    .sat_count_out (sat_count_out),
    .bus           (bus)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // one beat through an otherwise empty pipe with the consumer always ready
  task automatic xfer(input string tag, input logic [23:0] din, input logic lin,
                      input logic [15:0] rnd, input logic [23:0] exp, input logic clr);
    bus.m_ready_in = 1'b1;
    bus.s_valid_in = 1'b1;
    bus.s_data_in  = din;
    bus.s_last_in  = lin;
    rand_in        = rnd;
    step;
    bus.s_valid_in = 1'b0;
    bus.s_data_in  = 24'hA5A5A5;
    rand_in        = 16'h5A5A;
    chk({tag, "_v_early"}, 32'(bus.m_valid_out), 32'd0);
    step;
    chk({tag, "_valid"}, 32'(bus.m_valid_out), 32'd1);
    chk({tag, "_data"},  32'(bus.m_data_out),  32'(exp));
    chk({tag, "_last"},  32'(bus.m_last_out),  32'(lin));
    clear_in = clr;
    step;
    clear_in = 1'b0;
  endtask

  function automatic logic [23:0] pix(input int i);
    logic [7:0] r, g, b;
    r = 8'(i * 3);
    g = 8'(i * 5 + 1);
    b = 8'(i * 7 + 2);
    return {r, g, b};
  endfunction

  initial begin
    logic [15:0] pat;
    logic [3:0]  idx;
    int sent, rcv, cyc;

    rst_in = 1'b1;
    rand_in = 16'h0;
    enable_in = 1'b0;
    chroma_in = 1'b0;
    strength_in = 4'd0;
    clear_in = 1'b0;
    bus.s_valid_in = 1'b0;
    bus.s_data_in = '0;
    bus.s_last_in = 1'b0;
    bus.m_ready_in = 1'b1;
    #2;
    chk("rst_m_valid", 32'(bus.m_valid_out), 32'd0);
    chk("rst_m_data",  32'(bus.m_data_out),  32'd0);
    chk("rst_m_last",  32'(bus.m_last_out),  32'd0);
    chk("rst_sat",     32'(sat_count_out),   32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    step;
    chk("ready_after_rst", 32'(bus.s_ready_out), 32'd1);

    // mono +16 on every channel
    enable_in = 1'b1; chroma_in = 1'b0; strength_in = 4'd8;
    xfer("mono8", 24'h102030, 1'b1, 16'h0010, 24'h203040, 1'b0);
    chk("mono8_sat", 32'(sat_count_out), 32'd0);

    // top clip then bottom clip
    strength_in = 4'd15;
    xfer("clip_hi", 24'hF8F8F8, 1'b1, 16'h007F, 24'hFFFFFF, 1'b0);
    chk("clip_hi_sat", 32'(sat_count_out), 32'd1);
    strength_in = 4'd8;
    xfer("clip_lo", 24'h405060, 1'b1, 16'h0080, 24'h000000, 1'b0);
    chk("clip_lo_sat", 32'(sat_count_out), 32'd2);

    // strength change mid-line applies only after the line ends
    strength_in = 4'd0;
    xfer("midl_0", 24'h102030, 1'b0, 16'h0010, 24'h102030, 1'b0);
    strength_in = 4'd15;
    xfer("midl_1", 24'h112233, 1'b0, 16'h0010, 24'h112233, 1'b0);
    xfer("midl_2", 24'h0A0B0C, 1'b1, 16'h0010, 24'h0A0B0C, 1'b0);
    xfer("newline", 24'h102030, 1'b1, 16'h0010, 24'h2E3E4E, 1'b0);

    // chroma bytes: R=0x34, G=0x12, B=0x23 at strength 8
    chroma_in = 1'b1; strength_in = 4'd8;
    xfer("chroma", 24'h102030, 1'b1, 16'h1234, 24'h443253, 1'b0);

    // -1 * 3 >>> 3 floors to -1
    chroma_in = 1'b0; strength_in = 4'd3;
    xfer("floor", 24'h102030, 1'b1, 16'h00FF, 24'h0F1F2F, 1'b0);

    // disabled: passthrough, no clip even with a would-clip setting
    enable_in = 1'b0; strength_in = 4'd15;
    xfer("disabled", 24'hF8F8F8, 1'b1, 16'h007F, 24'hF8F8F8, 1'b0);
    chk("disabled_sat", 32'(sat_count_out), 32'd2);

    // 16-beat stream under pseudo-random backpressure, +1 per channel
    enable_in = 1'b1; chroma_in = 1'b0; strength_in = 4'd1; rand_in = 16'h0008;
    pat = 16'b1101_0111_0110_1011;
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 16 && cyc < 300) begin
      idx = 4'(cyc);
      bus.m_ready_in = pat[idx];
      bus.s_valid_in = (sent < 16);
      bus.s_data_in  = pix(sent);
      bus.s_last_in  = (sent == 7) || (sent == 15);
      #1;
      if (bus.m_ready_in)
        chk("stream_ready", 32'(bus.s_ready_out), 32'd1);
      if (bus.m_valid_out && bus.m_ready_in) begin
        chk($sformatf("stream_data%0d", rcv), 32'(bus.m_data_out), 32'(pix(rcv) + 24'h010101));
        chk($sformatf("stream_last%0d", rcv), 32'(bus.m_last_out),
            32'((rcv == 7) || (rcv == 15)));
        rcv++;
      end
      if (bus.s_valid_in && bus.s_ready_out) sent++;
      @(negedge clk_in);
      cyc++;
    end
    bus.s_valid_in = 1'b0;
    bus.m_ready_in = 1'b1;
    chk("stream_sent", 32'(sent), 32'd16);
    chk("stream_rcv",  32'(rcv),  32'd16);
    step;
    chk("stream_drained", 32'(bus.m_valid_out), 32'd0);
    chk("stream_sat", 32'(sat_count_out), 32'd2);

    // drive the counter past 0xFFFF with back-to-back clipped beats
    strength_in = 4'd15; rand_in = 16'h007F;
    bus.s_data_in = 24'hF8F8F8; bus.s_last_in = 1'b1;
    bus.s_valid_in = 1'b1;
    repeat (65540) @(posedge clk_in);
    @(negedge clk_in);
    bus.s_valid_in = 1'b0;
    repeat (3) step;
    chk("sat_full", 32'(sat_count_out), 32'h0000FFFF);
    xfer("sat_hold", 24'hF8F8F8, 1'b1, 16'h007F, 24'hFFFFFF, 1'b0);
    chk("sat_hold_cnt", 32'(sat_count_out), 32'h0000FFFF);
    xfer("clr_clip", 24'hF8F8F8, 1'b1, 16'h007F, 24'hFFFFFF, 1'b1);
    chk("clr_clip_cnt", 32'(sat_count_out), 32'd1);
    clear_in = 1'b1;
    step;
    clear_in = 1'b0;
    chk("clr_alone_cnt", 32'(sat_count_out), 32'd0);

    // fill both stages under backpressure, then reset mid-stream
    bus.m_ready_in = 1'b0;
    enable_in = 1'b1; strength_in = 4'd15; rand_in = 16'h0010;
    bus.s_valid_in = 1'b1; bus.s_data_in = 24'h102030; bus.s_last_in = 1'b0;
    step;
    bus.s_data_in = 24'h405060;
    step;
    bus.s_valid_in = 1'b0;
    chk("full_ready",  32'(bus.s_ready_out), 32'd0);
    chk("full_valid",  32'(bus.m_valid_out), 32'd1);
    chk("full_data",   32'(bus.m_data_out),  32'h002E3E4E);
    step;
    chk("stall_hold",  32'(bus.m_data_out),  32'h002E3E4E);
    rst_in = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.m_valid_out), 32'd0);
    chk("midrst_data",  32'(bus.m_data_out),  32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step;
    chk("midrst_ready", 32'(bus.s_ready_out), 32'd1);
    chk("midrst_empty", 32'(bus.m_valid_out), 32'd0);
    strength_in = 4'd8;
    xfer("post_rst", 24'h102030, 1'b1, 16'h0010, 24'h203040, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grain_inject.md
GRAIN_INJECT -- requirements
Module: grain_inject

Interface
REQ-001 Parameter CHANNEL_W, default 8, bits per colour channel; pixel word is 3*CHANNEL_W bits {R,G,B}, R in the MSBs.
REQ-002 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rand_in  input  16  pseudo-random word from the free-running 16-bit LFSR; sampled only when an input beat is accepted.
REQ-005 enable_in  input  1  grain enable request.
REQ-006 chroma_in  input  1  0 = monochrome grain, 1 = per-channel grain.
REQ-007 strength_in  input  4  grain strength, 0..15.
REQ-008 clear_in  input  1  synchronous clear of sat_count_out.
REQ-009 s_valid_in / s_ready_out  input / output  1 / 1  input stream handshake.
REQ-010 s_data_in  input  3*CHANNEL_W  input pixel.
REQ-011 s_last_in  input  1  marks the last pixel of a line.
REQ-012 m_valid_out / m_ready_in  output / input  1 / 1  output stream handshake.
REQ-013 m_data_out  output  3*CHANNEL_W  processed pixel.
REQ-014 m_last_out  output  1  s_last_in delayed with its pixel.
REQ-015 sat_count_out  output  16  count of output pixels in which at least one channel clipped.

Function
REQ-016 Beat transfers on either port SHALL occur only on cycles where valid and ready are both 1.
REQ-017 The datapath SHALL be two register stages (S1 capture, S2 result), each with its own valid flag; latency is 2 cycles from accept to m_valid_out with m_ready_in held at 1.
REQ-018 S2 SHALL load when empty or when its beat is consumed. S1 SHALL load when empty or when advancing into S2.
REQ-019 s_ready_out = !v1 | !v2 | m_ready_in, so that full throughput (1 beat/cycle) is sustained under continuous ready.
REQ-020 Data, last flag and noise SHALL be held stable in a stage while m_valid_out=1 and m_ready_in=0; no beat is lost or duplicated.
REQ-021 The active settings (enable, chroma, strength) SHALL be latched from the inputs on the first accepted beat after reset and on the first accepted beat after any accepted beat with s_last_in=1. They SHALL be held for all other beats; changes take effect only at line boundaries.
REQ-022 Noise byte selection: monochrome uses rand_in[7:0] for all channels. Chroma uses rand_in[7:0] for R, rand_in[15:8] for G and rand_in[11:4] for B. Each byte is interpreted as signed two's complement.
REQ-023 Scaled noise per channel SHALL be (byte * strength) >>> 3, arithmetic shift with floor rounding, computed at 12 bits signed; range -240..+238.
REQ-024 Output channel = clamp(channel + scaled noise, 0, 2^CHANNEL_W-1), computed without overflow.
REQ-025 A channel counts as clipped when the unclamped sum is < 0 or > 2^CHANNEL_W-1.
REQ-026 If active enable=0 or strength=0, data SHALL pass through unmodified, with no clipping and the same latency.
REQ-027 sat_count_out SHALL increment by 1 per consumed output beat that has any clipped channel, and SHALL saturate at 0xFFFF.
REQ-028 When clear_in=1, the next sat_count_out value SHALL be 1 if a clipped beat is consumed in that cycle, otherwise 0.

Reset
REQ-029 While rst_in=1, and immediately on its assertion: v1=v2=0, m_valid_out=0, m_data_out=0, m_last_out=0, sat_count_out=0, active settings=0, line-start flag=1.
REQ-030 Assertion of rst_in mid-stream SHALL discard in-flight beats. The first beat accepted after release SHALL relatch the settings.
REQ-031 s_ready_out SHALL be 1 one cycle after reset release.

Verification
REQ-032 Mono, strength=8, rand_in[7:0]=0x10, pixel 0x102030 -> m_data_out 0x203040 exactly 2 cycles later; sat_count_out stays 0.
REQ-033 Strength=15, rand_in[7:0]=0x7F, pixel 0xF8F8F8 -> 0xFFFFFF and sat_count_out=1. Then strength=8, rand_in[7:0]=0x80 (at the next line start), pixel 0x405060 -> 0x000000 and sat_count_out=2.
REQ-034 Stream 16 beats at full rate with m_ready_in toggled pseudo-randomly -> all 16 pixels and last flags emerge in order with none dropped or duplicated; throughput is 1 beat/cycle when m_ready_in=1.
REQ-035 Change strength_in from 0 to 15 mid-line -> rest of the line passes through unmodified; grain is applied from the first pixel after s_last_in.
REQ-036 Preload sat_count_out to 0xFFFF via clipped beats -> it holds 0xFFFF. clear_in pulsed together with a clipped beat -> 1. clear_in pulsed alone -> 0.
REQ-037 Assert rst_in with both stages full and m_ready_in=0 -> m_valid_out drops to 0 immediately. The first beat after release is processed with newly latched settings.
